eka_dmem_responder: RTL and testbench
=====================================

# eka_dmem_responder

Data-side memory responder for the Eka single-cycle core. It sits on the far end of the core's data port, consuming `data_addr`, `mem_wr_data`, `mem_wr_mask`, `mem_wr` and `mem_rd`, and producing `mem_rd_data` and `data_stall`. It models a word-organised, byte-lane-enabled backing memory with a configurable number of wait states. It holds the core stalled until each access completes.

## Interface
- `ADDR_WIDTH`, 32: width of `data_addr`.
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0001_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_STATES`, 2: extra stall cycles per access, 0..15.
- `clk` input 1: clock; all state changes on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `data_addr` input ADDR_WIDTH: byte address from core.
- `mem_wr_data` input 32: lane-replicated write data.
- `mem_wr_mask` input 4: byte-lane enables; bit i writes bits [8i+7:8i].
- `mem_wr` input 1: write request.
- `mem_rd` input 1: read request.
- `mem_rd_data` output 32: full aligned word; core performs lane select and extension.
- `data_stall` output 1: core must hold request and not retire.
- `bus_err` output 1: sticky out-of-range flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `mem_rd|mem_wr` and address accepted, `data_stall`=1 combinationally in the same cycle; latch word index `data_addr[log2(DEPTH_WORDS)+1:2]`, `mem_wr_data`, `mem_wr_mask`, `mem_wr`; load counter with `WAIT_STATES`. Go WAIT if `WAIT_STATES`>0, else RESP.
- WAIT: `data_stall`=1; counter decrements each cycle; at counter==1, go RESP.
- On every entry to RESP: capture the addressed word into the read register (pre-write contents).
- RESP: `data_stall`=0; `mem_rd_data` = read register; if latched write, commit masked bytes at this cycle's rising edge; then go IDLE unconditionally.
- Outside RESP, `mem_rd_data`=0.
- `mem_rd` and `mem_wr` both high: treated as a write; `mem_rd_data` returns pre-write word.
- `mem_wr` with `mem_wr_mask`=0: full handshake, no bytes change.
- Request inputs changing during WAIT/RESP are ignored; latched values are used.
- A new request in the cycle after RESP is a new access (full stall sequence again).
- `data_addr[1:0]` ignored for indexing.
- Memory array is not reset; contents survive `reset_n`.

## Timing
- Reset (asynchronous, while `reset_n`=0): state IDLE, counter 0, read register 0, `mem_rd_data`=0, `bus_err`=0; `data_stall` = 0 while `reset_n` low regardless of inputs.
- Reset during WAIT/RESP: access aborted; pending write not committed.
- Access latency: exactly `WAIT_STATES`+1 cycles with `data_stall`=1, then 1 RESP cycle with `data_stall`=0; core retires on RESP edge.
- No request in IDLE: `data_stall`=0, no state change.
- Back-to-back accesses: minimum `WAIT_STATES`+2 cycles each; no idle gap required.

## Configuration
- `EKA_DMEM_ERR_EN` defined: request with address outside [`BASE_ADDR`, `BASE_ADDR`+4*`DEPTH_WORDS`) is not accepted. It produces no stall, `mem_rd_data`=0, and no write. `bus_err` sets on that cycle's edge and stays 1 until reset.
- `EKA_DMEM_ERR_EN` undefined: no range check. The index is the address modulo depth, so every request is accepted and aliases. `bus_err` is tied 0.

## Test plan
- Reset then idle: `reset_n` low 3 cycles, release, no requests for 5 cycles -> `data_stall`=0, `mem_rd_data`=0, `bus_err`=0 throughout.
- Word write/read, `WAIT_STATES`=2: write 32'hDEAD_BEEF to 0x0001_0010, mask 4'hF -> `data_stall` high 3 cycles then low 1. Read same address -> 3 stall cycles, then `mem_rd_data`=32'hDEAD_BEEF in the RESP cycle.
- Byte lanes: after above, write data 32'h5555_5555 mask 4'b0100 to 0x0001_0012 -> read of 0x0001_0010 returns 32'hDE55_BEEF.
- `WAIT_STATES`=0: read of 0x0001_0000 -> exactly 1 stall cycle, then RESP. Two consecutive reads give the pattern stall, resp, stall, resp.
- Reset mid-access: start write 32'h1234_5678 to 0x0001_0020, assert `reset_n`=0 during WAIT -> `data_stall` drops immediately; later read of 0x0001_0020 returns prior contents.
- Out of range, with `EKA_DMEM_ERR_EN`: read 0x0000_0100 -> no stall, `mem_rd_data`=0, `bus_err`=1 next cycle and sticky. Without it: same read aliases to word 0x40 and stalls normally.

Source files
------------

// File: rtl/eka_dmem_responder.sv
// Data-side memory responder: word-organised byte-lane memory with WAIT_STATES stall cycles per access.
// Optional feature macro EKA_DMEM_ERR_EN: reject out-of-range addresses and raise a sticky bus_err.
module eka_dmem_responder #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           mem_wr_data,
    input  logic [3:0]            mem_wr_mask,
    input  logic                  mem_wr,
    input  logic                  mem_rd,
    output logic [31:0]           mem_rd_data,
    output logic                  data_stall,
    output logic                  bus_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wmask;
    logic               r_wr;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_in_range;
    logic               w_accept;
    logic [IDX_W-1:0]   w_addr_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_unused;

    assign w_req      = mem_rd | mem_wr;
    assign w_addr_idx = data_addr[IDX_W+1:2];
    assign w_accept   = w_req & w_in_range;
    assign w_unused   = ^data_addr;

`ifdef EKA_DMEM_ERR_EN
    // One extra bit so BASE_ADDR + size cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] LO_ADDR = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
    logic r_bus_err;

    assign w_in_range = ({1'b0, data_addr} >= LO_ADDR) && ({1'b0, data_addr} < HI_ADDR);
    assign bus_err    = r_bus_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_err <= 1'b0;
        end else if (r_state == S_IDLE && w_req && !w_in_range) begin
            r_bus_err <= 1'b1;
        end
    end
`else
    assign w_in_range = 1'b1;
    assign bus_err    = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        data_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    data_stall = 1'b1;
                    w_next     = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                data_stall = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // The request is combinational in IDLE, so reset must mask it explicitly.
        if (!reset_n) begin
            data_stall = 1'b0;
        end
    end

    // With zero wait states RESP follows IDLE directly, before the index is latched.
    assign w_rd_idx    = (r_state == S_IDLE) ? w_addr_idx : r_idx;
    assign mem_rd_data = (r_state == S_RESP) ? r_rdata : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_accept) begin
                r_cnt <= 4'(WAIT_STATES);
                r_wr  <= mem_wr;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_next == S_RESP && r_state != S_RESP) begin
                r_rdata <= r_mem[w_rd_idx];
            end
        end
    end

    // Request payload and the backing array carry no reset; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_accept) begin
            r_idx   <= w_addr_idx;
            r_wdata <= mem_wr_data;
            r_wmask <= mem_wr_mask;
        end
        if (r_state == S_RESP && r_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wmask[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_eka_dmem_responder.sv
// Self-checking bench for eka_dmem_responder: instance A (2 wait states) and instance B (0 wait states).
module tb_eka_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_mask, b_mask;
    logic        a_wr, a_rd, b_wr, b_rd;
    logic [31:0] a_rdata, b_rdata;
    logic        a_stall, b_stall, a_err, b_err;

    eka_dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .data_addr(a_addr), .mem_wr_data(a_wdata),
        .mem_wr_mask(a_mask), .mem_wr(a_wr), .mem_rd(a_rd),
        .mem_rd_data(a_rdata), .data_stall(a_stall), .bus_err(a_err)
    );

    eka_dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .data_addr(b_addr), .mem_wr_data(b_wdata),
        .mem_wr_mask(b_mask), .mem_wr(b_wr), .mem_rd(b_rd),
        .mem_rd_data(b_rdata), .data_stall(b_stall), .bus_err(b_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memories with per-byte "known" flags; unwritten bytes are never compared.
    logic [31:0] mdl_a [DEPTH];
    logic [31:0] mdl_b [DEPTH];
    bit   [3:0]  kn_a  [DEPTH];
    bit   [3:0]  kn_b  [DEPTH];

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 32'd4) % DEPTH);
    endfunction

    task automatic scramble_inputs(input bit sel);
        if (sel) begin
            b_addr = $urandom; b_wdata = $urandom; b_mask = 4'($urandom);
            b_wr = 1'($urandom); b_rd = 1'($urandom);
        end else begin
            a_addr = $urandom; a_wdata = $urandom; a_mask = 4'($urandom);
            a_wr = 1'($urandom); a_rd = 1'($urandom);
        end
    endtask

    // Starts #1 after a rising edge; returns #1 after the edge that ends RESP.
    task automatic access(input bit sel, input logic [31:0] addr, input logic wr, input logic rd,
                          input logic [31:0] wdata, input logic [3:0] mask, input bit scramble,
                          input string tag, output logic [31:0] rd_out);
        int          w;
        int          stalls;
        int          exp_st;
        bit          got;
        logic [31:0] exp;
        logic [31:0] bm;
        bit   [3:0]  kn;
        w      = word_of(addr);
        exp    = sel ? mdl_b[w] : mdl_a[w];
        kn     = sel ? kn_b[w] : kn_a[w];
        exp_st = sel ? 1 : 3;
        if (sel) begin
            b_addr = addr; b_wdata = wdata; b_mask = mask; b_wr = wr; b_rd = rd;
        end else begin
            a_addr = addr; a_wdata = wdata; a_mask = mask; a_wr = wr; a_rd = rd;
        end
        stalls = 0;
        got    = 1'b0;
        rd_out = 32'h0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (sel ? b_stall : a_stall) begin
                stalls++;
                if (scramble && stalls >= 2) scramble_inputs(sel);
            end else begin
                rd_out = sel ? b_rdata : a_rdata;
                got    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (sel) begin b_wr = 1'b0; b_rd = 1'b0; end
        else     begin a_wr = 1'b0; a_rd = 1'b0; end

        n_checks++;
        if (!got || stalls != exp_st)
            $display("FAIL %s stall_cycles got=%0d exp=%0d resp_seen=%0b", tag, stalls, exp_st, got);
        else
            n_pass++;
        if (kn != 4'h0) begin
            bm = {{8{kn[3]}}, {8{kn[2]}}, {8{kn[1]}}, {8{kn[0]}}};
            n_checks++;
            if ((rd_out & bm) !== (exp & bm))
                $display("FAIL %s rd_data got=%h exp=%h (known lanes %b)", tag, rd_out, exp, kn);
            else
                n_pass++;
        end
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    if (sel) begin mdl_b[w][8*i +: 8] = wdata[8*i +: 8]; kn_b[w][i] = 1'b1; end
                    else     begin mdl_a[w][8*i +: 8] = wdata[8*i +: 8]; kn_a[w][i] = 1'b1; end
                end
            end
        end
    endtask

    task automatic test_reset();
        a_addr = BASE; a_wdata = 32'h0; a_mask = 4'hF; a_wr = 1'b0; a_rd = 1'b1;
        b_addr = BASE; b_wdata = 32'h0; b_mask = 4'hF; b_wr = 1'b0; b_rd = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_stall !== 1'b0 || b_stall !== 1'b0)
                $display("FAIL reset_stall got=%b%b exp=00", a_stall, b_stall);
            else n_pass++;
            n_checks++;
            if (a_rdata !== 32'h0 || a_err !== 1'b0)
                $display("FAIL reset_outputs rd_data=%h bus_err=%b exp=0/0", a_rdata, a_err);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        a_rd = 1'b0; b_rd = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_stall !== 1'b0 || b_stall !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0)
                $display("FAIL idle stall=%b%b rd_data=%h bus_err=%b exp=0,0,0,0",
                         a_stall, b_stall, a_rdata, a_err);
            else n_pass++;
        end
    endtask

    task automatic test_word_and_lanes();
        logic [31:0] r;
        @(posedge clk); #1;
        access(0, 32'h0001_0010, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, "word_wr", r);
        access(0, 32'h0001_0010, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, "word_rd", r);
        n_checks++;
        if (r !== 32'hDEAD_BEEF) $display("FAIL word_value got=%h exp=deadbeef", r);
        else n_pass++;
        access(0, 32'h0001_0012, 1'b1, 1'b0, 32'h5555_5555, 4'b0100, 1'b0, "lane_wr", r);
        access(0, 32'h0001_0010, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, "lane_rd", r);
        n_checks++;
        if (r !== 32'hDE55_BEEF) $display("FAIL lane_value got=%h exp=de55beef", r);
        else n_pass++;
    endtask

    task automatic test_rdwr_and_mask0();
        logic [31:0] r;
        @(posedge clk); #1;
        access(0, 32'h0001_0010, 1'b1, 1'b1, 32'h0BAD_F00D, 4'hF, 1'b0, "rdwr_prewrite", r);
        access(0, 32'h0001_0010, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'h0, 1'b0, "mask0_wr", r);
        access(0, 32'h0001_0010, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, "mask0_rd", r);
        n_checks++;
        if (r !== 32'h0BAD_F00D) $display("FAIL mask0_value got=%h exp=0badf00d", r);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] r;
        logic [31:0] v;
        bit   [3:0]  pat;
        v = $urandom;
        @(posedge clk); #1;
        access(1, BASE, 1'b1, 1'b0, v, 4'hF, 1'b0, "ws0_wr", r);
        access(1, BASE, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, "ws0_rd", r);
        b_addr = BASE; b_rd = 1'b1; b_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[3-i] = b_stall;
            if (!b_stall) begin
                n_checks++;
                if (b_rdata !== v) $display("FAIL ws0_b2b_data got=%h exp=%h", b_rdata, v);
                else n_pass++;
            end
        end
        @(posedge clk); #1;
        b_rd = 1'b0;
        n_checks++;
        if (pat !== 4'b1010) $display("FAIL ws0_pattern got=%b exp=1010", pat);
        else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] r;
        logic [31:0] addr;
        bit          sel, wr, rd;
        @(posedge clk); #1;
        for (int n = 0; n < 60; n++) begin
            sel  = 1'($urandom);
            addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            wr   = 1'($urandom);
            rd   = wr ? 1'($urandom) : 1'b1;
            access(sel, addr, wr, rd, $urandom, 4'($urandom), ~sel, "random", r);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        @(posedge clk); #1;
        access(0, 32'h0001_0020, 1'b1, 1'b0, 32'hA5A5_0F0F, 4'hF, 1'b0, "mid_prior", r);
        a_addr = 32'h0001_0020; a_wdata = 32'h1234_5678; a_mask = 4'hF; a_wr = 1'b1; a_rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (a_stall !== 1'b1) $display("FAIL mid_in_wait stall got=%b exp=1", a_stall);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (a_stall !== 1'b0 || a_rdata !== 32'h0)
            $display("FAIL mid_reset_drop stall=%b rd_data=%h exp=0/0", a_stall, a_rdata);
        else n_pass++;
        a_wr = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        access(0, 32'h0001_0020, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, "mid_after", r);
        n_checks++;
        if (r !== 32'hA5A5_0F0F) $display("FAIL mid_not_committed got=%h exp=a5a50f0f", r);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] r;
        @(posedge clk); #1;
        access(0, 32'h0001_0100, 1'b1, 1'b0, 32'hCAFE_0100, 4'hF, 1'b0, "oor_prime", r);
`ifdef EKA_DMEM_ERR_EN
        a_addr = 32'h0000_0100; a_rd = 1'b1; a_wr = 1'b1; a_wdata = 32'h0; a_mask = 4'hF;
        @(negedge clk);
        n_checks++;
        if (a_stall !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0)
            $display("FAIL oor_reject stall=%b rd_data=%h bus_err=%b exp=0/0/0", a_stall, a_rdata, a_err);
        else n_pass++;
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_err !== 1'b1 || a_stall !== 1'b0)
                $display("FAIL oor_sticky bus_err=%b stall=%b exp=1/0", a_err, a_stall);
            else n_pass++;
        end
        @(posedge clk); #1;
        access(0, 32'h0001_0100, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, "oor_no_write", r);
`else
        access(0, 32'h0000_0100, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, "oor_alias", r);
        n_checks++;
        if (r !== 32'hCAFE_0100 || a_err !== 1'b0)
            $display("FAIL oor_alias_value got=%h bus_err=%b exp=cafe0100/0", r, a_err);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_word_and_lanes();
        test_rdwr_and_mask0();
        test_zero_wait();
        test_reset_mid();
        test_out_of_range();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
